// File: rtl/fifo_rd_stream_pkg.sv
// Shared types and constants for the FIFO read-side stream stage.
package fifo_rd_stream_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } rs_state_e;

  localparam int MIN_BUF_DEPTH = 3;

endpackage

// File: rtl/fifo_rd_stream_buf.sv
// rd_stream_buf: small circular output buffer with push/pop, head data and occupancy.
module rd_stream_buf
  import fifo_rd_stream_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  parameter  int BUF_DEPTH  = 4,
  localparam int PTR_W      = $clog2(BUF_DEPTH),
  localparam int OCC_W      = $clog2(BUF_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [OCC_W-1:0]      occ
);

  if (BUF_DEPTH < MIN_BUF_DEPTH || BUF_DEPTH > 16) begin : g_depth_check
    $error("rd_stream_buf: BUF_DEPTH must be in 3..16");
  end

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic                  do_push;
  logic                  do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] nxt;
    nxt = (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    return nxt;
  endfunction

  assign do_pop    = pop && (occ != '0);
  assign do_push   = push && ((occ != OCC_W'(BUF_DEPTH)) || do_pop);
  assign head_data = mem[head];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (do_push) begin
        mem[tail] <= push_data;
        tail      <= ptr_inc(tail);
      end
      if (do_pop) begin
        head <= ptr_inc(head);
      end
      unique case ({do_push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side drain stage: credit-tracked FIFO reads into an output buffer, valid/ready stream out.
// Optional feature macro RD_STREAM_CNT_EN adds the word_cnt handshake counter output.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  err_underflow
`ifdef RD_STREAM_CNT_EN
  ,
  output logic [15:0]           word_cnt
`endif
);

  localparam int OCC_W = $clog2(BUF_DEPTH + 1);
  localparam logic [OCC_W:0] CREDIT_MAX = (OCC_W + 1)'(BUF_DEPTH);

  rs_state_e        state;
  rs_state_e        state_nxt;
  logic             inflight;
  logic [OCC_W-1:0] occ;
  logic [OCC_W:0]   credit_used;
  logic             push;
  logic             pop;
  logic             buf_clear;

  // An in-flight read already owns a buffer slot, so it counts against the credit.
  assign credit_used = {1'b0, occ} + {{OCC_W{1'b0}}, inflight};

  rd_stream_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (buf_clear),
    .push      (push),
    .push_data (fifo_data_out),
    .pop       (pop),
    .head_data (m_data),
    .occ       (occ)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      inflight <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= fifo_rd_en;
    end
  end

  // In FLUSH the buffer is cleared and any word landing from the FIFO is dropped.
  always_comb begin
    state_nxt  = state;
    fifo_rd_en = 1'b0;
    m_valid    = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    buf_clear  = 1'b0;
    case (state)
      RUN: begin
        fifo_rd_en = !flush && !fifo_empty && (credit_used < CREDIT_MAX);
        m_valid    = (occ != '0);
        pop        = m_valid && m_ready;
        push       = inflight;
        if (flush) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        buf_clear = 1'b1;
        if (!flush && !inflight) begin
          state_nxt = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_underflow <= 1'b0;
    end else if (fifo_underflow) begin
      err_underflow <= 1'b1;
    end
  end

`ifdef RD_STREAM_CNT_EN
  // Free-running handshake count; flush deliberately leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt <= '0;
    end else if (pop) begin
      word_cnt <= word_cnt + 16'd1;
    end
  end
`endif

endmodule
